// File: rtl/dest_packetizer_pkg.sv
// dest_packetizer_pkg: default widths and state encoding shared by the dest insert/extract blocks
package dest_packetizer_pkg;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int ID_WIDTH_DEF = 3;
  typedef enum logic [1:0] {HEADER, PAYLOAD, DISCARD} state_t;
endpackage

// File: rtl/dest_extract_if.sv
// dest_extract_if: AXI4-Stream beat bundle; master drives tvalid/tlast/tdata/tid, slave drives tready
interface dest_extract_if #(parameter int DW = 8, parameter int IW = 3);
  logic tvalid;
  logic tready;
  logic tlast;
  logic [DW-1:0] tdata;
  logic [IW-1:0] tid;
  modport master (output tvalid, tlast, tdata, tid, input tready);
  modport slave (input tvalid, tlast, tdata, tid, output tready);
endinterface

// File: rtl/axi4s_reg_slice.sv
// axi4s_reg_slice: one-deep registered AXI4-Stream stage; in_* beat -> out_* one cycle later, holds while stalled
module axi4s_reg_slice #(
  parameter int DW = 8,
  parameter int IW = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic in_last,
  input  logic [DW-1:0] in_data,
  input  logic [IW-1:0] in_id,
  output logic out_valid,
  input  logic out_ready,
  output logic out_last,
  output logic [DW-1:0] out_data,
  output logic [IW-1:0] out_id
);
  assign in_ready = !out_valid || out_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_last <= 1'b0;
      out_data <= '0;
      out_id <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_last <= in_last;
        out_data <= in_data;
        out_id <= in_id;
      end
    end
  end
endmodule

// File: rtl/dest_extract.sv
// dest_extract: strips the header beat of each packet and forwards payload with the header id on initiator.tid
// Ports: aclk, areset (sync, active-high); target (slave stream in); initiator (master stream out, tid valid);
// hdr_only_drop pulse on header-only packet; id_err pulse on bad header when DEST_EXTRACT_ID_CHECK_EN is defined.
module dest_extract
  import dest_packetizer_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ID_WIDTH = ID_WIDTH_DEF
) (
  input  logic aclk,
  input  logic areset,
  dest_extract_if.slave target,
  dest_extract_if.master initiator,
  output logic hdr_only_drop
`ifdef DEST_EXTRACT_ID_CHECK_EN
  , output logic id_err
`endif
);
  state_t state;
  logic [ID_WIDTH-1:0] id_q;
  logic slice_ready;
  logic acc;
  logic hdr_bad;
`ifdef DEST_EXTRACT_ID_CHECK_EN
  if (ID_WIDTH < DATA_WIDTH) begin : g_chk
    assign hdr_bad = |target.tdata[DATA_WIDTH-1:ID_WIDTH];
  end else begin : g_nochk
    assign hdr_bad = 1'b0;
  end
`else
  assign hdr_bad = 1'b0;
`endif
  // headers and discarded beats never enter the slice, so they are absorbed even while it stalls
  assign target.tready = (state != PAYLOAD) || slice_ready;
  assign acc = target.tvalid && target.tready;
  always_ff @(posedge aclk) begin
    if (areset) begin
      state <= HEADER;
      id_q <= '0;
      hdr_only_drop <= 1'b0;
`ifdef DEST_EXTRACT_ID_CHECK_EN
      id_err <= 1'b0;
`endif
    end else begin
      hdr_only_drop <= acc && state == HEADER && target.tlast;
`ifdef DEST_EXTRACT_ID_CHECK_EN
      id_err <= acc && state == HEADER && hdr_bad;
`endif
      if (acc && state == HEADER) id_q <= target.tdata[ID_WIDTH-1:0];
      if (acc) state <= target.tlast ? HEADER : state == HEADER ? (hdr_bad ? DISCARD : PAYLOAD) : state;
    end
  end
  // tid is captured with each beat so a following header cannot alter a stalled beat
  axi4s_reg_slice #(.DW(DATA_WIDTH), .IW(ID_WIDTH)) u_slice (
    .clk(aclk),
    .rst(areset),
    .in_valid(target.tvalid && state == PAYLOAD),
    .in_ready(slice_ready),
    .in_last(target.tlast),
    .in_data(target.tdata),
    .in_id(id_q),
    .out_valid(initiator.tvalid),
    .out_ready(initiator.tready),
    .out_last(initiator.tlast),
    .out_data(initiator.tdata),
    .out_id(initiator.tid)
  );
endmodule

// File: tb/tb_dest_extract.sv
// tb_dest_extract: scoreboard bench for dest_extract
module tb_dest_extract;
  logic aclk = 1'b0;
  logic areset = 1'b1;
  logic hdr_only_drop;
`ifdef DEST_EXTRACT_ID_CHECK_EN
  logic id_err;
  int n_err = 0;
`endif
  int n_tests = 0;
  int n_fail = 0;
  int n_drop = 0;
  bit tog = 1'b0;
  logic [11:0] q[$];
  logic [11:0] exp_beat;
  dest_extract_if #(.DW(8), .IW(3)) tgt();
  dest_extract_if #(.DW(8), .IW(3)) ini();
  dest_extract dut (
    .aclk(aclk),
    .areset(areset),
    .target(tgt),
    .initiator(ini),
    .hdr_only_drop(hdr_only_drop)
`ifdef DEST_EXTRACT_ID_CHECK_EN
    , .id_err(id_err)
`endif
  );
  always #5 aclk = ~aclk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] d, input logic l, input bit pay, input logic [2:0] id);
    int c = 0;
    tgt.tvalid = 1'b1;
    tgt.tdata = d;
    tgt.tlast = l;
    @(negedge aclk);
    while (!tgt.tready && c < 200) begin
      @(negedge aclk);
      c++;
    end
    if (c >= 200) chk("send_timeout", 1, 0);
    if (pay) q.push_back({l, id, d});
    @(posedge aclk);
    #1;
    tgt.tvalid = 1'b0;
  endtask
  task automatic drain();
    int c = 0;
    while (q.size() != 0 && c < 200) begin
      @(posedge aclk);
      #1;
      c++;
    end
    chk("drain", q.size(), 0);
  endtask
  always @(negedge aclk) begin
    if (!areset && hdr_only_drop) n_drop++;
`ifdef DEST_EXTRACT_ID_CHECK_EN
    if (!areset && id_err) n_err++;
`endif
    if (!areset && ini.tvalid && ini.tready) begin
      if (q.size() == 0) chk("unexpected_beat", {ini.tlast, ini.tid, ini.tdata}, 0);
      else begin
        exp_beat = q.pop_front();
        chk("beat", {ini.tlast, ini.tid, ini.tdata}, exp_beat);
      end
    end
  end
  initial forever begin
    @(posedge aclk);
    #2;
    if (tog) ini.tready = !ini.tready;
  end
  initial begin
    int d0;
    tgt.tvalid = 1'b0;
    tgt.tlast = 1'b0;
    tgt.tdata = '0;
    tgt.tid = '0;
    ini.tready = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    areset = 1'b0;
    chk("rst_valid", ini.tvalid, 0);
    chk("rst_out", {ini.tlast, ini.tid, ini.tdata, hdr_only_drop}, 0);
    // basic packet with one-cycle latency
    d0 = n_drop;
    send(8'h05, 0, 0, 0);
    send(8'hA1, 0, 1, 5);
    chk("lat_valid", ini.tvalid, 1);
    chk("lat_data", ini.tdata, 8'hA1);
    send(8'hA2, 1, 1, 5);
    drain();
    chk("no_drop", n_drop - d0, 0);
    // header accepted while previous last beat stalls
    ini.tready = 1'b0;
    send(8'h02, 0, 0, 0);
    send(8'h11, 1, 1, 2);
    send(8'h06, 0, 0, 0);
    chk("stall_tid", ini.tid, 2);
    chk("stall_data", ini.tdata, 8'h11);
    tog = 1'b1;
    send(8'h22, 1, 1, 6);
    drain();
    tog = 1'b0;
    ini.tready = 1'b1;
    // header-only packet dropped
    d0 = n_drop;
    send(8'h03, 1, 0, 0);
    send(8'h01, 0, 0, 0);
    send(8'h44, 1, 1, 1);
    drain();
    chk("hdr_drop", n_drop - d0, 1);
    // long output stall with slice full
    ini.tready = 1'b0;
    send(8'h07, 0, 0, 0);
    send(8'h31, 0, 1, 7);
    tgt.tvalid = 1'b1;
    tgt.tdata = 8'h32;
    tgt.tlast = 1'b1;
    repeat (10) begin
      @(negedge aclk);
      chk("hold_tready", tgt.tready, 0);
      chk("hold_beat", {ini.tvalid, ini.tlast, ini.tid, ini.tdata}, {1'b1, 1'b0, 3'd7, 8'h31});
    end
    @(posedge aclk);
    #1;
    ini.tready = 1'b1;
    @(negedge aclk);
    chk("release_tready", tgt.tready, 1);
    q.push_back({1'b1, 3'd7, 8'h32});
    @(posedge aclk);
    #1;
    tgt.tvalid = 1'b0;
    drain();
    // reset mid-packet loses the in-flight beat
    send(8'h05, 0, 0, 0);
    send(8'hA1, 0, 0, 0);
    areset = 1'b1;
    @(posedge aclk);
    #1;
    areset = 1'b0;
    chk("mid_rst_out", {ini.tvalid, ini.tlast, ini.tid, ini.tdata, hdr_only_drop}, 0);
    send(8'h04, 0, 0, 0);
    send(8'h55, 1, 1, 4);
    drain();
`ifdef DEST_EXTRACT_ID_CHECK_EN
    d0 = n_err;
    send(8'h09, 0, 0, 0);
    send(8'hB1, 0, 0, 0);
    send(8'hB2, 0, 0, 0);
    send(8'hB3, 1, 0, 0);
    repeat (2) @(posedge aclk);
    #1;
    chk("id_err", n_err - d0, 1);
    send(8'h03, 0, 0, 0);
    send(8'hC1, 1, 1, 3);
    drain();
`endif
    repeat (3) @(posedge aclk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
